// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit frame path.
// Build with UART_TX_STOP2_EN defined for two stop bits per frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

`ifdef UART_TX_STOP2_EN
    localparam int unsigned STOP_BITS = 2;
`else
    localparam int unsigned STOP_BITS = 1;
`endif

endpackage

// File: rtl/uart_tx_frame_parity_calc.sv
// Combinational parity bit for a latched UART word; even = XOR, odd = XNOR.
module parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    always_comb begin
        parity_o = (par_typ_i == PAR_EVEN) ? (^data_i) : (~^data_i);
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, data LSB first, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN (see uart_pkg) for two stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  tx_out
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t        state_q,   state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_out_q,  tx_out_d;
    logic                  parity_c;
    logic                  accept_c;

    parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data_i   (data_q),
        .par_typ_i(par_typ_q),
        .parity_o (parity_c)
    );

    assign tx_ready = (state_q == IDLE) || ((state_q == STOP) && (stop_cnt_q == LAST_STOP));
    assign busy     = (state_q != IDLE);
    assign tx_out   = tx_out_q;
    assign accept_c = data_valid && tx_ready;

    // tx_out is driven from the current state, so each bit appears one edge after its state.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        tx_out_d   = 1'b1;

        if (accept_c) begin
            data_d    = p_data;
            par_en_d  = par_en;
            par_typ_d = par_typ;
        end

        case (state_q)
            IDLE: begin
                tx_out_d = 1'b1;
                if (accept_c) begin
                    state_d = START;
                end
            end
            START: begin
                tx_out_d  = 1'b0;
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                tx_out_d = data_q[bit_cnt_q];
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = par_en_q ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                tx_out_d   = parity_c;
                stop_cnt_d = 1'b0;
                state_d    = STOP;
            end
            STOP: begin
                tx_out_d = 1'b1;
                if (stop_cnt_q == LAST_STOP) begin
                    stop_cnt_d = 1'b0;
                    state_d    = accept_c ? START : IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            tx_out_q   <= tx_out_d;
        end
    end

endmodule
